// File: rtl/ow_pkg.sv
// Shared 1-Wire definitions: FSM state encoding, CRC8 polynomial and default frame width.
package ow_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2
  } ow_state_t;

  localparam logic [7:0] OW_CRC8_POLY  = 8'h8C;
  localparam int         OW_FRAME_BITS = 64;

endpackage

// File: rtl/ow_frame_assembler_if.sv
// Bit-stream input and frame/byte result bundle between the sampler and the slave command logic.
interface ow_frame_assembler_if
  import ow_pkg::*;
#(
  parameter int FRAME_BITS = OW_FRAME_BITS
);

  // Handshake: i_bit_ready is a one-cycle strobe with no backpressure; i_bit_val is
  // meaningful only while i_bit_ready=1. o_byte_valid, o_frame_valid and o_frame_abort
  // are one-cycle pulses; their data outputs hold until the next update.
  logic                  i_presence_pulse;
  logic                  i_bit_val;
  logic                  i_bit_ready;
  logic [7:0]            o_byte;
  logic                  o_byte_valid;
  logic [FRAME_BITS-1:0] o_frame;
  logic                  o_frame_valid;
  logic                  o_crc_ok;
  logic                  o_frame_abort;
  logic                  o_busy;
  ow_state_t             dbg_state;

  modport slave (
    input  i_presence_pulse, i_bit_val, i_bit_ready,
    output o_byte, o_byte_valid, o_frame, o_frame_valid, o_crc_ok, o_frame_abort, o_busy,
    output dbg_state
  );

  modport master (
    output i_presence_pulse, i_bit_val, i_bit_ready,
    input  o_byte, o_byte_valid, o_frame, o_frame_valid, o_crc_ok, o_frame_abort, o_busy,
    input  dbg_state
  );

endinterface

// File: rtl/ow_crc8_step.sv
// Single-bit update of the reflected 1-Wire CRC8, shared by slave and master datapaths.
module ow_crc8_step
  import ow_pkg::*;
#(
  parameter logic [7:0] POLY = OW_CRC8_POLY
) (
  input  logic [7:0] crc_in,
  input  logic       bit_in,
  output logic [7:0] crc_out
);

  logic fb;

  assign fb      = crc_in[0] ^ bit_in;
  assign crc_out = (crc_in >> 1) ^ (fb ? POLY : 8'h00);

endmodule

// File: rtl/ow_frame_assembler.sv
// Assembles sampled 1-Wire bits LSB-first into bytes and a frame, with a running CRC8 check.
module ow_frame_assembler
  import ow_pkg::*;
#(
  parameter int         FRAME_BITS = OW_FRAME_BITS,
  parameter logic [7:0] CRC_POLY   = OW_CRC8_POLY
) (
  input  logic                  clk,
  input  logic                  reset,
  ow_frame_assembler_if.slave   bus
);

  localparam int IW = $clog2(FRAME_BITS);

  ow_state_t  state, state_nxt;
  logic       pres_q;
  logic       pres_rise;
  logic [6:0] bit_cnt;
  logic [7:0] byte_sr;
  logic [7:0] crc;
  logic [7:0] crc_next;
  logic       last_bit;

  assign pres_rise     = bus.i_presence_pulse & ~pres_q;
  assign last_bit      = (bit_cnt == 7'(FRAME_BITS - 1));
  assign bus.o_busy    = (state == COLLECT);
  assign bus.dbg_state = state;

  ow_crc8_step #(.POLY(CRC_POLY)) u_crc_step (
    .crc_in  (crc),
    .bit_in  (bus.i_bit_val),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pres_rise) state_nxt = COLLECT;
      COLLECT: if (!pres_rise && bus.i_bit_ready && last_bit) state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pres_q            <= 1'b0;
      bit_cnt           <= '0;
      byte_sr           <= '0;
      crc               <= '0;
      bus.o_byte        <= '0;
      bus.o_byte_valid  <= 1'b0;
      bus.o_frame       <= '0;
      bus.o_frame_valid <= 1'b0;
      bus.o_crc_ok      <= 1'b0;
      bus.o_frame_abort <= 1'b0;
    end else begin
      pres_q            <= bus.i_presence_pulse;
      bus.o_byte_valid  <= 1'b0;
      bus.o_frame_valid <= 1'b0;
      bus.o_frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (pres_rise) begin
            bit_cnt      <= '0;
            byte_sr      <= '0;
            crc          <= '0;
            bus.o_crc_ok <= 1'b0;
          end
        end
        COLLECT: begin
          // A new presence edge restarts the frame and drops any bit strobed alongside it.
          if (pres_rise) begin
            bit_cnt           <= '0;
            byte_sr           <= '0;
            crc               <= '0;
            bus.o_crc_ok      <= 1'b0;
            bus.o_frame_abort <= 1'b1;
          end else if (bus.i_bit_ready) begin
            byte_sr                     <= {bus.i_bit_val, byte_sr[7:1]};
            bus.o_frame[bit_cnt[IW-1:0]] <= bus.i_bit_val;
            crc                         <= crc_next;
            bit_cnt                     <= last_bit ? 7'd0 : bit_cnt + 7'd1;
            if (bit_cnt[2:0] == 3'd7) begin
              bus.o_byte       <= {bus.i_bit_val, byte_sr[7:1]};
              bus.o_byte_valid <= 1'b1;
            end
          end
        end
        CHECK: begin
          // The trailing CRC byte is folded in, so a good frame leaves a zero remainder.
          bus.o_frame_valid <= 1'b1;
          bus.o_crc_ok      <= (crc == 8'h00);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ow_frame_assembler.sv
// Directed bench for ow_frame_assembler: ROM frame, bad CRC, abort, back-to-back, idle strobes, reset.
module tb_ow_frame_assembler;
  import ow_pkg::*;

  localparam int FB = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  ow_frame_assembler_if #(.FRAME_BITS(FB)) bus ();

  ow_frame_assembler #(.FRAME_BITS(FB), .CRC_POLY(8'h8C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_miss = 0;
  int n_byte = 0;
  int n_fv = 0;
  int n_abort = 0;
  int byte_at_abort = 0;
  int last_bv_cyc = 0;
  int fv_cyc = 0;
  int last_strobe = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // monitor: sample 2ns after the active edge
  always @(posedge clk) begin
    #2;
    if (!reset) begin
      if (bus.o_byte_valid) begin
        n_byte++;
        last_bv_cyc = cyc;
        chk("byte_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("byte", 64'(bus.o_byte), 64'(exp_q.pop_front()));
      end
      if (bus.o_frame_valid) begin
        n_fv++;
        fv_cyc = cyc;
      end
      if (bus.o_frame_abort) begin
        n_abort++;
        byte_at_abort = n_byte;
      end
    end
  end

  // drivers
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.i_bit_ready = 1'b0;
    bus.i_presence_pulse = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic presence(input bit with_strobe);
    @(negedge clk);
    bus.i_presence_pulse = 1'b1;
    if (with_strobe) begin
      bus.i_bit_ready = 1'b1;
      bus.i_bit_val   = 1'b1;
    end
    @(negedge clk);
    bus.i_bit_ready = 1'b0;
    repeat (9) @(negedge clk);
    bus.i_presence_pulse = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [63:0] data, input int n, input bit b2b);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.i_bit_val   = data[i];
      bus.i_bit_ready = 1'b1;
      last_strobe     = cyc;
      if (i % 8 == 7) exp_q.push_back(data[8*(i/8) +: 8]);
      if (!b2b) begin
        @(negedge clk);
        bus.i_bit_ready = 1'b0;
        @(negedge clk);
      end
    end
    if (b2b) begin
      @(negedge clk);
      bus.i_bit_ready = 1'b0;
    end
  endtask

  task automatic wait_frame(input int start, input string tag);
    int t;
    t = 0;
    while (n_fv == start && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 64'(n_fv - start), 64'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_frame"}, bus.o_frame, 64'd0);
    chk({tag, "_byte"}, 64'(bus.o_byte), 64'd0);
    chk({tag, "_pulses"}, 64'({bus.o_byte_valid, bus.o_frame_valid, bus.o_frame_abort}), 64'd0);
    chk({tag, "_crc_ok"}, 64'(bus.o_crc_ok), 64'd0);
    chk({tag, "_busy"}, 64'(bus.o_busy), 64'd0);
    chk({tag, "_state"}, 64'(bus.dbg_state), 64'(IDLE));
  endtask

  logic [63:0] rom  = 64'hA2000000_01B81C02;
  logic [63:0] bad  = 64'hA3000000_01B81C02;
  logic [63:0] misc = 64'h01234567_89ABCDEF;
  int          s_fv, s_byte;
  logic [63:0] held;

  initial begin
    bus.i_presence_pulse = 1'b0;
    bus.i_bit_val        = 1'b0;
    bus.i_bit_ready      = 1'b0;
    do_reset();
    chk_zero("reset");

    // ROM code, strobes 3 cycles apart
    presence(1'b0);
    chk("busy_collect", 64'(bus.o_busy), 64'd1);
    s_fv = n_fv; s_byte = n_byte;
    send_bits(rom, 64, 1'b0);
    wait_frame(s_fv, "rom_fv");
    chk("rom_frame", bus.o_frame, 64'hA2000000_01B81C02);
    chk("rom_crc_ok", 64'(bus.o_crc_ok), 64'd1);
    chk("rom_bytes", 64'(n_byte - s_byte), 64'd8);
    chk("rom_fv_after_bv", 64'(fv_cyc - last_bv_cyc), 64'd1);

    // presence clears crc_ok; corrupted CRC byte
    presence(1'b0);
    chk("crc_ok_cleared", 64'(bus.o_crc_ok), 64'd0);
    s_fv = n_fv;
    send_bits(bad, 64, 1'b0);
    wait_frame(s_fv, "bad_fv");
    chk("bad_frame", bus.o_frame, 64'hA3000000_01B81C02);
    chk("bad_crc_ok", 64'(bus.o_crc_ok), 64'd0);

    // abort after 20 bits, new presence edge coinciding with a strobe
    presence(1'b0);
    s_fv = n_fv;
    send_bits(rom, 20, 1'b0);
    s_byte = n_abort;
    presence(1'b1);
    chk("abort_pulse", 64'(n_abort - s_byte), 64'd1);
    chk("abort_busy", 64'(bus.o_busy), 64'd1);
    send_bits(rom, 64, 1'b0);
    wait_frame(s_fv, "abort_fv");
    chk("abort_frame", bus.o_frame, 64'hA2000000_01B81C02);
    chk("abort_crc_ok", 64'(bus.o_crc_ok), 64'd1);
    chk("abort_bytes_after", 64'(n_byte - byte_at_abort), 64'd8);

    // back-to-back strobes
    presence(1'b0);
    s_fv = n_fv;
    send_bits(rom, 64, 1'b1);
    wait_frame(s_fv, "b2b_fv");
    chk("b2b_frame", bus.o_frame, 64'hA2000000_01B81C02);
    chk("b2b_crc_ok", 64'(bus.o_crc_ok), 64'd1);
    chk("b2b_latency", 64'(fv_cyc - last_strobe), 64'd2);

    // strobes with no presence edge are ignored
    held = bus.o_frame;
    s_fv = n_fv; s_byte = n_byte;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.i_bit_val   = ~held[i];
      bus.i_bit_ready = 1'b1;
      @(negedge clk);
      bus.i_bit_ready = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("idle_frame", bus.o_frame, 64'hA2000000_01B81C02);
    chk("idle_events", 64'((n_fv - s_fv) + (n_byte - s_byte)), 64'd0);
    chk("idle_crc_ok", 64'(bus.o_crc_ok), 64'd1);
    chk("idle_busy", 64'(bus.o_busy), 64'd0);

    // reset in the middle of a frame, at bit 37
    presence(1'b0);
    send_bits(misc, 37, 1'b0);
    chk("mid_busy", 64'(bus.o_busy), 64'd1);
    do_reset();
    chk_zero("midreset");
    presence(1'b0);
    s_fv = n_fv;
    send_bits(rom, 64, 1'b0);
    wait_frame(s_fv, "post_fv");
    chk("post_frame", bus.o_frame, 64'hA2000000_01B81C02);
    chk("post_crc_ok", 64'(bus.o_crc_ok), 64'd1);

    repeat (3) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ow_frame_assembler.md
Name: ow_frame_assembler

Overview:
- Slave-side stage directly downstream of the bus input sampler.
- Consumes the sampler's presence-pulse indication and its per-bit value/ready strobes.
- Assembles received bits LSB-first into bytes and a FRAME_BITS-wide frame, running the 1-Wire CRC8 (X^8+X^5+X^4+1) in parallel.
- Reports each byte, the completed frame and CRC pass/fail to the slave command/ROM logic.

Parameters:
- FRAME_BITS, 64, bits per frame; multiple of 8, range 8..64.
- CRC_POLY, 8'h8C, reflected CRC8 polynomial, applied LSB-first.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- i_presence_pulse  input  1  high while the slave drives presence; a rising edge marks the start of a new transaction
- i_bit_val  input  1  sampled bit value; valid only when i_bit_ready=1
- i_bit_ready  input  1  single-cycle strobe, one per received bit
- o_byte  output  8  most recently completed byte
- o_byte_valid  output  1  one-cycle pulse; o_byte is valid
- o_frame  output  FRAME_BITS  assembled frame; first received bit at bit 0
- o_frame_valid  output  1  one-cycle pulse at frame completion
- o_crc_ok  output  1  CRC result of the last completed frame
- o_frame_abort  output  1  one-cycle pulse when a frame in progress is restarted
- o_busy  output  1  high in the COLLECT state

Behaviour:
- Reset, sampled on a clk edge with reset=1:
  - state=IDLE.
  - All outputs are 0, including o_frame and o_byte.
  - Internal bit counter, byte shift register and CRC register are cleared to 0.
  - The presence edge detector register is cleared to 0.
  - Reset wins over every other event in the same cycle.
- Presence edge: pres_rise = i_presence_pulse & ~pres_q, where pres_q is a registered copy of i_presence_pulse.
- States: IDLE, COLLECT, CHECK.
- IDLE:
  - On pres_rise: clear bit counter, shift register and CRC to 0; go to COLLECT.
  - i_bit_ready is ignored in this state.
- COLLECT:
  - On each i_bit_ready (without pres_rise in the same cycle):
    - byte_sr <= {i_bit_val, byte_sr[7:1]}.
    - o_frame[bit_cnt] <= i_bit_val.
    - fb = crc[0] ^ i_bit_val; crc <= (crc >> 1) ^ (fb ? CRC_POLY : 0).
    - bit_cnt <= bit_cnt + 1.
  - Byte completion: when bit_cnt[2:0]==7 at the strobe, o_byte <= {i_bit_val, byte_sr[7:1]} and o_byte_valid=1 in the following cycle.
  - Frame completion: when bit_cnt==FRAME_BITS-1 at the strobe, go to CHECK.
  - pres_rise in COLLECT (including the same cycle as i_bit_ready):
    - Discard the partial frame and any bit strobed in that cycle.
    - Clear bit counter, shift register and CRC; pulse o_frame_abort for 1 cycle; remain in COLLECT.
    - o_frame is not cleared; its stale bits are overwritten as new bits arrive.
- CHECK:
  - Lasts exactly 1 cycle.
  - o_frame_valid <= 1 and o_crc_ok <= (crc==8'h00); the check runs over all bits including the trailing CRC byte.
  - Go to IDLE. i_bit_ready is ignored.
- Latency:
  - o_byte_valid is high in the cycle after the 8th bit's strobe.
  - o_frame_valid is high in the cycle after the final o_byte_valid (2 cycles after the last strobe).
- Hold rules:
  - o_byte, o_frame and o_crc_ok hold their values until overwritten.
  - o_crc_ok is cleared to 0 on pres_rise.
- Width: bit_cnt is 7 bits; it never exceeds FRAME_BITS-1, so no wrap-around is possible.
- o_busy = (state==COLLECT).

Decomposition:
- Shared package ow_pkg holds:
  - the state encoding constants IDLE / COLLECT / CHECK;
  - OW_CRC8_POLY = 8'h8C;
  - the default frame width 64.
- One sub-module, ow_crc8_step: combinational single-bit CRC update.
  - Inputs crc_in[7:0], bit_in; output crc_out[7:0].
  - Reused by the future master-side CRC generator.

Test Plan:
- ROM code: after reset, a presence pulse (high for 10 cycles), then 64 strobes sending bytes 02,1C,B8,01,00,00,00,A2 LSB-first, strobes 3 cycles apart.
  - Expected: 8 o_byte_valid pulses carrying those byte values in order.
  - Expected: o_frame=64'hA2000000_01B81C02, o_frame_valid pulses once, o_crc_ok=1.
- Corrupted CRC: same frame with the last byte changed to A3 -> o_frame_valid=1, o_crc_ok=0.
- Abort: 20 bits sent, then a new presence rising edge coinciding with a strobe.
  - Expected: o_frame_abort pulses, and no o_byte_valid for the bit strobed in that cycle.
  - Then the full valid frame -> o_crc_ok=1, with exactly 8 byte pulses after the abort.
- Back-to-back strobes: i_bit_ready high on 64 consecutive cycles -> identical result to the ROM code scenario; o_frame_valid 2 cycles after the last strobe.
- Idle strobes and reset: strobes with no presence edge -> no outputs change. Reset asserted mid-frame at bit 37 -> all outputs 0 on the next cycle, and the next frame assembles correctly.
